// File: rtl/vend_ctrl_param_if.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl_param_if
// Description : Coin-acceptor / actuator bundle for the vending controller.
//               master = acceptor-side driver, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface vend_ctrl_param_if #(
  parameter int CREDIT_W = 4
);
  logic [1:0]          Coin;
  logic                Cancel;
  logic                Dispense;
  logic                Change_valid;
  logic [CREDIT_W-1:0] Change;
  logic [CREDIT_W-1:0] Credit;
  logic                Busy;

  modport master (
    output Coin, Cancel,
    input  Dispense, Change_valid, Change, Credit, Busy
  );

  modport slave (
    input  Coin, Cancel,
    output Dispense, Change_valid, Change, Credit, Busy
  );
endinterface
`default_nettype wire

// File: rtl/vend_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl_param
// Description : Parametrised Moore vending controller with change return,
//               cancel/refund and visible credit. Actuator outputs decode
//               from the registered state only.
//               Optional macro VEND_COIN_EDGE_EN: count each Coin bit on its
//               rising edge instead of on every high cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl_param #(
  parameter int PRICE    = 4,
  parameter int VALUE_A  = 1,
  parameter int VALUE_B  = 2,
  parameter int CREDIT_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  vend_ctrl_param_if.slave  bus
);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_COLLECT = 5'b00010,
    S_VEND    = 5'b00100,
    S_CHANGE  = 5'b01000,
    S_REFUND  = 5'b10000
  } state_t;

  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_N = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   VAL_A_X = (CREDIT_W+1)'(VALUE_A);
  localparam logic [CREDIT_W:0]   VAL_B_X = (CREDIT_W+1)'(VALUE_B);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n;
  // Shared amount register: excess after a vend, or the refund total.
  logic [CREDIT_W-1:0] amount, amount_n;

  logic [1:0]          coin_eff;
  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] excess;

  logic                dispense;
  logic                change_valid;
  logic [CREDIT_W-1:0] change;
  logic                busy;

`ifdef VEND_COIN_EDGE_EN
  logic [1:0] coin_prev;

  // Remember the previous Coin sample so a held level only counts once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) coin_prev <= 2'b00;
    else       coin_prev <= bus.Coin;
  end

  assign coin_eff = bus.Coin & ~coin_prev;
`else
  assign coin_eff = bus.Coin;
`endif

  assign coin_val = (coin_eff[0] ? VAL_A_X : '0) + (coin_eff[1] ? VAL_B_X : '0);
  assign sum      = {1'b0, credit} + coin_val;
  // Modular subtraction is exact: the true excess always fits CREDIT_W bits.
  assign excess   = sum[CREDIT_W-1:0] - PRICE_N;

  // State, credit and amount registers; reset discards everything pending.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      credit <= '0;
      amount <= '0;
    end else begin
      state  <= state_n;
      credit <= credit_n;
      amount <= amount_n;
    end
  end

  // Next-state, datapath updates and state-decoded actuator outputs.
  always_comb begin
    state_n      = state;
    credit_n     = credit;
    amount_n     = amount;
    dispense     = 1'b0;
    change_valid = 1'b0;
    change       = '0;
    busy         = 1'b0;
    case (state)
      S_IDLE, S_COLLECT: begin
        if (bus.Cancel) begin
          // Cancel wins over a same-cycle coin, which is refunded as well.
          credit_n = '0;
          if (sum != '0) begin
            amount_n = sum[CREDIT_W-1:0];
            state_n  = S_REFUND;
          end else begin
            state_n  = S_IDLE;
          end
        end else if (sum >= PRICE_X) begin
          amount_n = excess;
          credit_n = '0;
          state_n  = S_VEND;
        end else if (coin_val != '0) begin
          credit_n = sum[CREDIT_W-1:0];
          state_n  = S_COLLECT;
        end
      end
      S_VEND: begin
        dispense = 1'b1;
        busy     = 1'b1;
        state_n  = (amount != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE, S_REFUND: begin
        change_valid = 1'b1;
        change       = amount;
        busy         = 1'b1;
        amount_n     = '0;
        state_n      = S_IDLE;
      end
      default: begin
        state_n  = S_IDLE;
        credit_n = '0;
        amount_n = '0;
      end
    endcase
  end

  assign bus.Dispense     = dispense;
  assign bus.Change_valid = change_valid;
  assign bus.Change       = change;
  assign bus.Credit       = credit;
  assign bus.Busy         = busy;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_ctrl_param
// Description : Scoreboard bench for vend_ctrl_param (PRICE=4, A=1, B=2).
//               Expected pulses are queued by the stimulus and popped by an
//               independent monitor whenever Dispense or Change_valid fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl_param;

  localparam int CW = 4;

  typedef struct {
    bit             is_chg;
    logic [CW-1:0]  amt;
  } exp_t;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];

  vend_ctrl_param_if #(.CREDIT_W(CW)) bus ();

  vend_ctrl_param #(
    .PRICE(4), .VALUE_A(1), .VALUE_B(2), .CREDIT_W(CW)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input bit is_chg, input int amt);
    exp_t e;
    e.is_chg = is_chg;
    e.amt    = CW'(amt);
    exp_q.push_back(e);
  endtask

  // One input cycle: drive at negedge, sampled at posedge, released after.
  task automatic step(input logic [1:0] c, input logic k);
    @(negedge Clk);
    bus.Coin   = c;
    bus.Cancel = k;
    @(posedge Clk);
    #1;
    bus.Coin   = 2'b00;
    bus.Cancel = 1'b0;
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.Dispense || bus.Change_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: got disp=%0b cv=%0b change=%0d, expected no pulse",
                   bus.Dispense, bus.Change_valid, bus.Change);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.Dispense !== !e.is_chg || bus.Change_valid !== e.is_chg ||
              bus.Change !== e.amt) begin
            n_bad++;
            $display("FAIL pulse: got disp=%0b cv=%0b change=%0d, expected disp=%0b cv=%0b change=%0d",
                     bus.Dispense, bus.Change_valid, bus.Change,
                     !e.is_chg, e.is_chg, e.amt);
          end
        end
      end else begin
        n_cmp++;
        if (bus.Change !== '0) begin
          n_bad++;
          $display("FAIL change_idle: got %0d, expected 0", bus.Change);
        end
      end
    end
  end

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    Reset      = 1'b1;
    bus.Coin   = 2'b00;
    bus.Cancel = 1'b0;
    #12;
    chk("rst_credit", int'(bus.Credit), 0);
    chk("rst_busy", int'(bus.Busy), 0);
    chk("rst_dispense", int'(bus.Dispense), 0);
    chk("rst_change_valid", int'(bus.Change_valid), 0);
    chk("rst_change", int'(bus.Change), 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Four A coins (gap cycles keep them distinct in edge mode too).
    step(2'b01, 1'b0); chk("a1_credit", int'(bus.Credit), 1);
    step(2'b00, 1'b0);
    step(2'b01, 1'b0); chk("a2_credit", int'(bus.Credit), 2);
    step(2'b00, 1'b0);
    step(2'b01, 1'b0); chk("a3_credit", int'(bus.Credit), 3);
    step(2'b00, 1'b0);
    push(1'b0, 0);
    step(2'b01, 1'b0); chk("a4_credit", int'(bus.Credit), 0);
    chk("a4_busy", int'(bus.Busy), 1);
    repeat (3) step(2'b00, 1'b0);
    chk("idle_busy", int'(bus.Busy), 0);

    // B then both coins: total 5, change 1.
    step(2'b10, 1'b0); chk("b_credit", int'(bus.Credit), 2);
    step(2'b00, 1'b0);
    push(1'b0, 0);
    push(1'b1, 1);
    step(2'b11, 1'b0); chk("ab_credit", int'(bus.Credit), 0);
    repeat (3) step(2'b00, 1'b0);

    // A then Cancel: refund 1; Cancel with zero credit gives no pulse.
    step(2'b01, 1'b0); chk("c_credit", int'(bus.Credit), 1);
    step(2'b00, 1'b0);
    push(1'b1, 1);
    step(2'b00, 1'b1); chk("cancel_credit", int'(bus.Credit), 0);
    repeat (3) step(2'b00, 1'b0);
    step(2'b00, 1'b1); chk("cancel0_busy", int'(bus.Busy), 0);
    repeat (2) step(2'b00, 1'b0);

    // A then B+Cancel together: refund 3.
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    push(1'b1, 3);
    step(2'b10, 1'b1); chk("bc_credit", int'(bus.Credit), 0);
    chk("bc_busy", int'(bus.Busy), 1);
    repeat (3) step(2'b00, 1'b0);

    // Coins during VEND and CHANGE are ignored.
    step(2'b10, 1'b0);
    step(2'b00, 1'b0);
    push(1'b0, 0);
    push(1'b1, 1);
    step(2'b11, 1'b0);
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    repeat (2) step(2'b00, 1'b0);
    chk("ignored_credit", int'(bus.Credit), 0);

    // Async reset mid-COLLECT.
    step(2'b10, 1'b0); chk("pre_rst_credit", int'(bus.Credit), 2);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_credit", int'(bus.Credit), 0);
    chk("midrst_busy", int'(bus.Busy), 0);
    #1 Reset = 1'b0;
    step(2'b00, 1'b0);
    step(2'b01, 1'b0); chk("post_rst_credit", int'(bus.Credit), 1);
    push(1'b1, 1);
    step(2'b00, 1'b1);
    repeat (2) step(2'b00, 1'b0);

    // Coin[0] held for three cycles.
    @(negedge Clk);
    bus.Coin = 2'b01;
    repeat (3) @(posedge Clk);
    #1 bus.Coin = 2'b00;
`ifdef VEND_COIN_EDGE_EN
    chk("held_credit", int'(bus.Credit), 1);
    push(1'b1, 1);
`else
    chk("held_credit", int'(bus.Credit), 3);
    push(1'b1, 3);
`endif
    step(2'b00, 1'b1);
    repeat (3) step(2'b00, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
Parametrised Moore-style vending controller; generalised successor of the fixed two-coin, fixed-price vending FSM.
- Price, coin values and credit width are parameters.
- Adds change return, a cancel/refund path and a visible credit count.
- Sits between the coin-acceptor front end and the dispense/change actuator drivers. All actuator outputs are decoded from registered state only.

Parameters:
PRICE, 4, item price in base coin units (default 4 = 2.0 at 0.5 per unit).
VALUE_A, 1, value in units of coin type A (Coin[0]).
VALUE_B, 2, value in units of coin type B (Coin[1]).
CREDIT_W, 4, width of credit/change datapath; must hold PRICE+VALUE_A+VALUE_B-1.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Coin  input  2  bit0 = type A inserted, bit1 = type B inserted; both high = both coins in the same cycle.
Cancel  input  1  request refund of current credit.
Dispense  output  1  one-cycle pulse: release item.
Change_valid  output  1  one-cycle pulse: Change holds the amount to return.
Change  output  CREDIT_W  change/refund amount in units; 0 when Change_valid=0.
Credit  output  CREDIT_W  current accumulated credit.
Busy  output  1  high in VEND, CHANGE and REFUND; coins are ignored while Busy.

Behaviour:
- Reset is asynchronous, Clk is the only clock, and Reset has absolute priority.
- Reset state is IDLE, with Credit=0, Dispense=0, Change_valid=0, Change=0, Busy=0.
- States: IDLE, COLLECT, VEND, CHANGE, REFUND. Encoding is one-hot, 5 bits.
- Coin value per cycle: v = (Coin[0]?VALUE_A:0) + (Coin[1]?VALUE_B:0). Sum is computed at CREDIT_W+1 bits. No saturation is needed given the CREDIT_W rule.
- IDLE / COLLECT transitions:
  - Cancel=1 and credit+v>0: Change register <= credit+v, credit <= 0, go to REFUND. Cancel beats a coin in the same cycle; that coin is refunded too.
  - Cancel=1 and credit+v=0: stay in or return to IDLE. No pulse.
  - Otherwise, if credit+v >= PRICE: excess register <= credit+v-PRICE, credit <= 0, go to VEND.
  - Otherwise, if v>0: credit <= credit+v, go to COLLECT.
  - Otherwise: hold state.
- VEND:
  - Dispense=1 for exactly one cycle, Busy=1.
  - Next state is CHANGE if excess>0, else IDLE.
- CHANGE: Change_valid=1, Change=excess, Busy=1 for one cycle; then IDLE. Excess is cleared on exit.
- REFUND: Change_valid=1, Change=refund amount, Busy=1 for one cycle; then IDLE.
- Coins and Cancel are ignored in VEND, CHANGE and REFUND. The acceptor must hold off on Busy.
- Latency: the coin that completes the price is sampled at edge k. Dispense is high from edge k to edge k+1. Change_valid, if any, is high from edge k+1 to edge k+2.
- Credit is a register output and updates on the same edge the coin is sampled. It reads 0 from the edge entering VEND or REFUND.
- Reset mid-operation (any state): immediate return to IDLE. Credit and pending excess are discarded, with no refund pulse.
- Illegal or unreachable state: next state IDLE, outputs 0.

Optional Feature:
VEND_COIN_EDGE_EN
- Defined: each Coin bit passes through a registered rising-edge detector (prev-sample register cleared by Reset).
  - A coin level held for N cycles counts once.
  - Adds no latency to the count; the edge is taken from the current input vs the previous sample.
  - Both bits rising together count as both coins.
- Undefined: Coin is level-sampled, so every cycle with a bit high adds its value.

Test Plan:
- PRICE=4, A,A,A,A on four consecutive single-cycle pulses -> Credit 1,2,3. Dispense=1 in the cycle after the 4th edge. No Change_valid. Credit=0.
- B, then Coin=2'b11 -> Credit=2, then total 5. Dispense pulse, then Change_valid=1 with Change=1 the following cycle. Back to IDLE.
- A, then Cancel -> Change_valid=1 with Change=1 for one cycle, Credit=0, no Dispense. Cancel with credit 0 -> no pulse.
- A, then Coin=B and Cancel in the same cycle -> REFUND with Change=3. Coin=A applied during VEND/CHANGE -> ignored; Credit stays 0 afterwards.
- B, then assert Reset for one cycle mid-COLLECT (async, between edges) -> outputs 0 immediately, Credit=0. The next A gives Credit=1.
- Coin[0] held high for 3 cycles from IDLE -> Credit=1 with VEND_COIN_EDGE_EN, Credit=3 without it.
